// File: rtl/tt_pfd_pkg.sv
// Shared types and helpers for the sampled PFD / TDC block.
package tt_pfd_pkg;

    typedef enum logic [1:0] {
        PFD_IDLE = 2'd0,
        PFD_UP   = 2'd1,
        PFD_DOWN = 2'd2
    } pfd_state_e;

    // Increment that sticks at max instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
        return (val >= max) ? max : val + 32'd1;
    endfunction

endpackage

// File: rtl/tt_sync_edge.sv
// Multi-flop synchroniser with a history flop and rising-edge detect.
// With TT_PFD_SCAN_EN defined, the flops double as a scan shift chain.
module tt_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic din,
`ifdef TT_PFD_SCAN_EN
    input  logic scan_en,
    input  logic scan_in,
    output logic scan_out,
`endif
    output logic rise
);

    // sr[STAGES-1] is the last synchroniser flop, sr[STAGES] the history flop.
    logic [STAGES:0] sr;
    logic            shift_in;

`ifdef TT_PFD_SCAN_EN
    assign shift_in = scan_en ? scan_in : din;
    assign scan_out = sr[STAGES];
`else
    assign shift_in = din;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-1:0], shift_in};
        end
    end

    assign rise = sr[STAGES-1] & ~sr[STAGES];

endmodule

// File: rtl/tt_pfd_tdc.sv
// Sampled three-state PFD with signed phase-error counter and lock detector.
// Optional scan chain over the synchronisers: define TT_PFD_SCAN_EN.
module tt_pfd_tdc
    import tt_pfd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ERR_W       = 8,
    parameter int unsigned LOCK_THRESH = 2,
    parameter int unsigned LOCK_COUNT  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clk_ref,
    input  logic                    i_clk_fb,
`ifdef TT_PFD_SCAN_EN
    input  logic                    i_scan_en,
    input  logic                    i_scan_in,
    output logic                    o_scan_out,
`endif
    output logic                    o_up,
    output logic                    o_down,
    output logic signed [ERR_W-1:0] o_err,
    output logic                    o_err_valid,
    output logic                    o_locked
);

    localparam logic [31:0] CNT_MAX = (32'd1 << (ERR_W - 1)) - 32'd1;
    localparam int unsigned LC_W    = $clog2(LOCK_COUNT + 1);

    logic ref_rise;
    logic fb_rise;
    logic hold;

`ifdef TT_PFD_SCAN_EN
    logic scan_mid;

    tt_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ref (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .din      (i_clk_ref),
        .scan_en  (i_scan_en),
        .scan_in  (i_scan_in),
        .scan_out (scan_mid),
        .rise     (ref_rise)
    );

    tt_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_fb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .din      (i_clk_fb),
        .scan_en  (i_scan_en),
        .scan_in  (scan_mid),
        .scan_out (o_scan_out),
        .rise     (fb_rise)
    );

    // Everything past the synchronisers freezes while the chain shifts.
    assign hold = i_scan_en;
`else
    tt_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ref (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .din     (i_clk_ref),
        .rise    (ref_rise)
    );

    tt_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_fb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .din     (i_clk_fb),
        .rise    (fb_rise)
    );

    assign hold = 1'b0;
`endif

    pfd_state_e       state, state_d;
    logic [ERR_W-1:0] cnt, cnt_d;
    logic             emit;
    logic             emit_neg;
    logic [ERR_W-1:0] emit_mag;
    logic [ERR_W-1:0] err_val;
    logic [LC_W-1:0]  lock_cnt, lock_next;
    logic             good;
    logic             locked_next;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state;
        cnt_d    = ERR_W'(sat_inc(32'(cnt), CNT_MAX));
        emit     = 1'b0;
        emit_neg = 1'b0;
        emit_mag = '0;
        unique case (state)
            PFD_IDLE: begin
                cnt_d = '0;
                if (ref_rise && fb_rise) begin
                    emit = 1'b1;
                end else if (ref_rise) begin
                    state_d = PFD_UP;
                    cnt_d   = ERR_W'(1);
                end else if (fb_rise) begin
                    state_d = PFD_DOWN;
                    cnt_d   = ERR_W'(1);
                end
            end
            PFD_UP: begin
                // Extra ref edges while waiting for fb are slips and leave cnt running.
                if (fb_rise) begin
                    emit     = 1'b1;
                    emit_mag = cnt;
                    state_d  = ref_rise ? PFD_UP : PFD_IDLE;
                    cnt_d    = ref_rise ? ERR_W'(1) : '0;
                end
            end
            PFD_DOWN: begin
                if (ref_rise) begin
                    emit     = 1'b1;
                    emit_neg = 1'b1;
                    emit_mag = cnt;
                    state_d  = fb_rise ? PFD_DOWN : PFD_IDLE;
                    cnt_d    = fb_rise ? ERR_W'(1) : '0;
                end
            end
            default: begin
                state_d = PFD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign err_val     = emit_neg ? -emit_mag : emit_mag;
    assign good        = (32'(emit_mag) <= LOCK_THRESH);
    assign lock_next   = good ? LC_W'(sat_inc(32'(lock_cnt), LOCK_COUNT)) : '0;
    assign locked_next = good && (32'(lock_next) == LOCK_COUNT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= PFD_IDLE;
            cnt         <= '0;
            o_up        <= 1'b0;
            o_down      <= 1'b0;
            o_err       <= '0;
            o_err_valid <= 1'b0;
            lock_cnt    <= '0;
            o_locked    <= 1'b0;
        end else begin
            o_err_valid <= emit & ~hold;
            if (!hold) begin
                state  <= state_d;
                cnt    <= cnt_d;
                o_up   <= (state_d == PFD_UP);
                o_down <= (state_d == PFD_DOWN);
                if (emit) begin
                    o_err    <= $signed(err_val);
                    lock_cnt <= lock_next;
                    o_locked <= locked_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_tt_pfd_tdc.sv
// Scoreboard bench for tt_pfd_tdc; expected errors are queued as edges are driven.
// Scan scenario is compiled in with TT_PFD_SCAN_EN.
module tb_tt_pfd_tdc;

    logic              i_clk   = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              clk_ref = 1'b0;
    logic              clk_fb  = 1'b0;
    logic              up;
    logic              down;
    logic signed [7:0] err;
    logic              err_valid;
    logic              locked;
`ifdef TT_PFD_SCAN_EN
    logic              scan_en = 1'b0;
    logic              scan_in = 1'b0;
    logic              scan_out;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int lc = 0;
    logic prev_valid = 1'b0;

    tt_pfd_tdc #(
        .SYNC_STAGES (2),
        .ERR_W       (8),
        .LOCK_THRESH (2),
        .LOCK_COUNT  (16)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clk_ref   (clk_ref),
        .i_clk_fb    (clk_fb),
`ifdef TT_PFD_SCAN_EN
        .i_scan_en   (scan_en),
        .i_scan_in   (scan_in),
        .o_scan_out  (scan_out),
`endif
        .o_up        (up),
        .o_down      (down),
        .o_err       (err),
        .o_err_valid (err_valid),
        .o_locked    (locked)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Monitor: pops expected errors on each strobe and tracks lock with its own counter model.
    always @(negedge i_clk) begin
        int e;
        if (!i_rst_n) begin
            lc         = 0;
            prev_valid = 1'b0;
        end else begin
            if (prev_valid) check("strobe_width", int'(err_valid), 0);
            if (err_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("err", int'(err), e);
                    lc = (e <= 2 && e >= -2) ? ((lc < 16) ? lc + 1 : 16) : 0;
                    check("locked", int'(locked), (lc == 16) ? 1 : 0);
                end
            end
            check("up_down_exclusive", int'(up & down), 0);
            prev_valid = err_valid;
        end
    end

    // d > 0: ref leads by d cycles; d < 0: fb leads by -d cycles; d == 0: simultaneous.
    task automatic measure(input int d, output int up_n, output int dn_n);
        int mag;
        mag  = (d < 0) ? -d : d;
        up_n = 0;
        dn_n = 0;
        if (d >= 0) clk_ref = 1'b1;
        else        clk_fb  = 1'b1;
        for (int i = 0; i < mag; i++) begin
            @(negedge i_clk);
            up_n += int'(up);
            dn_n += int'(down);
        end
        clk_ref = 1'b1;
        clk_fb  = 1'b1;
        exp_q.push_back((d > 127) ? 127 : d);
        for (int i = 0; i < 9; i++) begin
            @(negedge i_clk);
            up_n += int'(up);
            dn_n += int'(down);
            if (i == 3) begin
                clk_ref = 1'b0;
                clk_fb  = 1'b0;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge i_clk);
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        int   u;
        int   dn;
        int   any_pulse;
        int   err_before;

        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_up", int'(up), 0);
        check("rst_down", int'(down), 0);
        check("rst_err", int'(err), 0);
        check("rst_valid", int'(err_valid), 0);
        check("rst_locked", int'(locked), 0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // Ref leads by 5, then fb leads by 3
        measure(5, u, dn);
        check("lead5_up_cycles", u, 5);
        check("lead5_down_cycles", dn, 0);
        drain();
        measure(-3, u, dn);
        check("lag3_down_cycles", dn, 3);
        check("lag3_up_cycles", u, 0);
        drain();
        repeat (5) @(negedge i_clk);
        check("err_holds", int'(err), -3);

        // Simultaneous edges
        measure(0, u, dn);
        check("simul_up_cycles", u, 0);
        check("simul_down_cycles", dn, 0);
        drain();

        // Cycle slips with saturation
        for (int i = 0; i < 300; i++) begin
            clk_ref = ((i % 40) < 20);
            @(negedge i_clk);
        end
        check("slip_up_held", int'(up), 1);
        clk_ref = 1'b0;
        clk_fb  = 1'b1;
        exp_q.push_back(127);
        repeat (4) @(negedge i_clk);
        clk_fb = 1'b0;
        repeat (6) @(negedge i_clk);
        drain();
        check("slip_err_sat", int'(err), 127);

        // Lock acquisition, loss and reacquisition
        for (int k = 0; k < 16; k++) begin
            measure((k % 2 == 0) ? 1 : -2, u, dn);
            if (k == 14) check("lock_not_at_15", int'(locked), 0);
        end
        drain();
        check("lock_at_16", int'(locked), 1);
        measure(5, u, dn);
        drain();
        check("lock_lost", int'(locked), 0);
        for (int k = 0; k < 16; k++) measure((k % 2 == 0) ? 1 : -2, u, dn);
        drain();
        check("lock_regained", int'(locked), 1);

        // Reset in the middle of an UP measurement
        clk_ref = 1'b1;
        repeat (4) @(negedge i_clk);
        check("mid_up_active", int'(up), 1);
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_up", int'(up), 0);
        check("mid_rst_err", int'(err), 0);
        check("mid_rst_valid", int'(err_valid), 0);
        check("mid_rst_locked", int'(locked), 0);
        exp_q.delete();
        clk_ref = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n   = 1'b1;
        any_pulse = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            any_pulse |= int'(up | down | err_valid);
        end
        check("post_rst_quiet", any_pulse, 0);

        measure(4, u, dn);
        drain();
        check("post_rst_measure", u, 4);

`ifdef TT_PFD_SCAN_EN
        // Scan shift from an idle, all-zero chain
        repeat (6) @(negedge i_clk);
        err_before = int'(err);
        scan_en    = 1'b1;
        for (int k = 0; k < 6; k++) begin
            scan_in = (k == 0);
            @(negedge i_clk);
            check((k < 5) ? "scan_out_early" : "scan_out_sixth", int'(scan_out), (k < 5) ? 0 : 1);
            check("scan_up_held", int'(up), 0);
            check("scan_err_held", int'(err), err_before);
            check("scan_valid_low", int'(err_valid), 0);
        end
        scan_en = 1'b0;
        scan_in = 1'b0;
        any_pulse = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            any_pulse |= int'(up | down);
        end
        check("post_scan_quiet", any_pulse, 0);
`else
        err_before = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
